// File: rtl/ccx_rst_seq.sv
// ccx_rst_seq: reset / debug-init sequencer for the CCX cluster.
// Synchronizes the asynchronous debug-init request, releases adbginit_l and
// then rst_l after fixed counted holds, services warm resets while running,
// and registers scan enable. Sequencing freezes while scan is active, except
// that a debug request always pulls the sequencer back to the start.
module ccx_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int DBG_CYCLES  = 8,
    parameter int RST_CYCLES  = 16,
    parameter int CNT_W       = 8
) (
    input  logic rclk,
    input  logic arst,
    input  logic dbginit_req_l,
    input  logic wrm_rst_req,
    input  logic se_in,
    output logic rst_l,
    output logic se,
    output logic adbginit_l,
    output logic rst_done
);

    typedef enum logic [1:0] {
        ST_DBG   = 2'd0,
        ST_RHOLD = 2'd1,
        ST_RUN   = 2'd2,
        ST_WARM  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DBG_LAST = CNT_W'(DBG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   se_q;
    logic                   dbg_sync;
    logic                   dbg_force;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rst_l_q;
    logic                   adbg_l_q;
    logic                   done_q;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], dbginit_req_l};
    assign dbg_sync = sync_q[SYNC_STAGES-1];

    // A request is acted on as soon as it reaches the last synchronizer
    // stage's input, so the outputs drop on the same edge dbg_sync goes low.
    // Release, in contrast, waits for dbg_sync itself to read high.
    assign dbg_force = ~dbg_sync | ~sync_q[SYNC_STAGES-2];

    // Debug-request synchronizer; reset value means "request asserted".
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Scan enable is simply registered toward the buffer.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            se_q <= 1'b0;
        end else begin
            se_q <= se_in;
        end
    end

    // Sequencer FSM; outputs are set together with the state they belong to.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_DBG;
            cnt_q    <= '0;
            rst_l_q  <= 1'b0;
            adbg_l_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (dbg_force) begin
            state_q  <= ST_DBG;
            cnt_q    <= '0;
            rst_l_q  <= 1'b0;
            adbg_l_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (!se_q) begin
            case (state_q)
                ST_DBG: begin
                    if (cnt_q == DBG_LAST) begin
                        state_q  <= ST_RHOLD;
                        cnt_q    <= '0;
                        adbg_l_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RHOLD, ST_WARM: begin
                    if (cnt_q == RST_LAST) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        rst_l_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (wrm_rst_req) begin
                        state_q <= ST_WARM;
                        cnt_q   <= '0;
                        rst_l_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_DBG;
                    cnt_q    <= '0;
                    rst_l_q  <= 1'b0;
                    adbg_l_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_l      = rst_l_q;
    assign se         = se_q;
    assign adbginit_l = adbg_l_q;
    assign rst_done   = done_q;

endmodule
